// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
//   Shared definitions for the immediate-extension block of the 16-bit
//   6-stage RISC pipeline: width constants and the extension-mode encoding.
// -----------------------------------------------------------------------------
package imm_ext_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM6_W = 6;
  localparam int unsigned IMM9_W = 9;

  typedef enum logic [1:0] {
    EXT6   = 2'b00,
    EXT9   = 2'b01,
    EXT6X2 = 2'b10,
    EXT9X2 = 2'b11
  } imm_mode_e;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
//   Purely combinational immediate extenders and mode mux.
//
//   Ports:
//     imm6    in   short immediate (always sign-extended)
//     imm9    in   long immediate {rb[2:0], imm6}
//     mode    in   00 EXT6, 01 EXT9, 10 EXT6x2, 11 EXT9x2
//     sext6_o out  sign extension of imm6
//     ext9_o  out  extension of imm9
//     sel_o   out  mode-selected operand (optionally doubled)
//
//   Build option: IMM_EXT_SEXT9_EN -- when defined the 9-bit path is
//   sign-extended instead of zero-extended.
// -----------------------------------------------------------------------------
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = imm_ext_pkg::DATA_W,
  parameter int unsigned IMM6_W = imm_ext_pkg::IMM6_W,
  parameter int unsigned IMM9_W = imm_ext_pkg::IMM9_W
) (
  input  logic [IMM6_W-1:0] imm6,
  input  logic [IMM9_W-1:0] imm9,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] sext6_o,
  output logic [DATA_W-1:0] ext9_o,
  output logic [DATA_W-1:0] sel_o
);

  always_comb begin
    sext6_o = {{(DATA_W-IMM6_W){imm6[IMM6_W-1]}}, imm6};
  end

  always_comb begin
`ifdef IMM_EXT_SEXT9_EN
    ext9_o = {{(DATA_W-IMM9_W){imm9[IMM9_W-1]}}, imm9};
`else
    ext9_o = {{(DATA_W-IMM9_W){1'b0}}, imm9};
`endif
  end

  // Doubling is a modulo-2^DATA_W left shift: the MSB is simply dropped.
  always_comb begin
    sel_o = '0;
    case (imm_mode_e'(mode))
      EXT6:    sel_o = sext6_o;
      EXT9:    sel_o = ext9_o;
      EXT6X2:  sel_o = {sext6_o[DATA_W-2:0], 1'b0};
      EXT9X2:  sel_o = {ext9_o[DATA_W-2:0], 1'b0};
      default: sel_o = '0;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_extend_unit.sv
// -----------------------------------------------------------------------------
// imm_extend_unit
//   Decode/register-read stage immediate extension with a one-cycle
//   enable-gated pipeline register for the selected operand.
//
//   Ports:
//     clk      in   pipeline clock, rising edge
//     reset    in   asynchronous active-high reset (clears imm_q, valid_q)
//     en       in   stage enable; 0 holds the registered outputs
//     imm6     in   short immediate
//     imm9     in   long immediate {rb[2:0], imm6}
//     mode     in   00 EXT6, 01 EXT9, 10 EXT6x2, 11 EXT9x2
//     in_valid in   decode instruction carries an immediate
//     sext6_o  out  combinational sign extension of imm6 (not reset)
//     ext9_o   out  combinational extension of imm9 (not reset)
//     imm_q    out  registered, mode-selected operand
//     valid_q  out  registered in_valid
//
//   Build option: IMM_EXT_SEXT9_EN -- sign-extend the 9-bit path.
// -----------------------------------------------------------------------------
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = imm_ext_pkg::DATA_W,
  parameter int unsigned IMM6_W = imm_ext_pkg::IMM6_W,
  parameter int unsigned IMM9_W = imm_ext_pkg::IMM9_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [IMM6_W-1:0] imm6,
  input  logic [IMM9_W-1:0] imm9,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic [DATA_W-1:0] sext6_o,
  output logic [DATA_W-1:0] ext9_o,
  output logic [DATA_W-1:0] imm_q,
  output logic              valid_q
);

  logic [DATA_W-1:0] sel;
  logic [DATA_W-1:0] imm_d;
  logic              valid_d;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM6_W (IMM6_W),
    .IMM9_W (IMM9_W)
  ) u_core (
    .imm6    (imm6),
    .imm9    (imm9),
    .mode    (mode),
    .sext6_o (sext6_o),
    .ext9_o  (ext9_o),
    .sel_o   (sel)
  );

  always_comb begin
    imm_d   = imm_q;
    valid_d = valid_q;
    if (en) begin
      imm_d   = sel;
      valid_d = in_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      imm_q   <= imm_d;
      valid_q <= valid_d;
    end
  end

endmodule : imm_extend_unit

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [5:0]  imm6;
  logic [8:0]  imm9;
  logic [1:0]  mode;
  logic        in_valid;
  logic [15:0] sext6_o;
  logic [15:0] ext9_o;
  logic [15:0] imm_q;
  logic        valid_q;

  int tests = 0;
  int fails = 0;

  imm_extend_unit dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .imm6     (imm6),
    .imm9     (imm9),
    .mode     (mode),
    .in_valid (in_valid),
    .sext6_o  (sext6_o),
    .ext9_o   (ext9_o),
    .imm_q    (imm_q),
    .valid_q  (valid_q)
  );

  always #5 clk = ~clk;

  // Reference model: interpret the fields as integers and do plain arithmetic.
  function automatic int ref_v6(input logic [5:0] i6);
    int v;
    v = int'(i6);
    if (v >= 32) v = v - 64;
    return v;
  endfunction

  function automatic int ref_v9(input logic [8:0] i9);
    int v;
    v = int'(i9);
`ifdef IMM_EXT_SEXT9_EN
    if (v >= 256) v = v - 512;
`endif
    return v;
  endfunction

  function automatic logic [15:0] to16(input int v);
    logic [31:0] w;
    w = v;
    return w[15:0];
  endfunction

  function automatic logic [15:0] ref_sel(input logic [5:0] i6, input logic [8:0] i9,
                                          input logic [1:0] m);
    int v;
    v = (m == 2'b01 || m == 2'b11) ? ref_v9(i9) : ref_v6(i6);
    if (m == 2'b10 || m == 2'b11) v = v * 2;
    return to16(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; in_valid = 1'b1; imm6 = 6'h3F; imm9 = 9'h1FF; mode = 2'b00;
    step(); step();
    tests++;
    if (imm_q !== 16'h0000) begin fails++; $display("FAIL reset_imm_q got=%h exp=0000", imm_q); end
    tests++;
    if (valid_q !== 1'b0) begin fails++; $display("FAIL reset_valid_q got=%b exp=0", valid_q); end
    en = 1'b0;
    reset = 1'b0;
    step();
    tests++;
    if (imm_q !== 16'h0000) begin fails++; $display("FAIL reset_hold_en0 got=%h exp=0000", imm_q); end
  endtask

  task automatic test_sign_boundaries();
    logic [5:0]  vals [3] = '{6'b111111, 6'b011111, 6'b100000};
    logic [15:0] exps [3] = '{16'hFFFF, 16'h001F, 16'hFFE0};
    en = 1'b1; in_valid = 1'b1; mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      imm6 = vals[i];
      #1;
      tests++;
      if (sext6_o !== exps[i]) begin
        fails++; $display("FAIL sign_comb[%0d] got=%h exp=%h", i, sext6_o, exps[i]);
      end
      step();
      tests++;
      if (imm_q !== exps[i]) begin
        fails++; $display("FAIL sign_reg[%0d] got=%h exp=%h", i, imm_q, exps[i]);
      end
    end
  endtask

  task automatic test_ext9();
    logic [15:0] exp_ff;
`ifdef IMM_EXT_SEXT9_EN
    exp_ff = 16'hFFFF;
`else
    exp_ff = 16'h01FF;
`endif
    en = 1'b1; in_valid = 1'b1; mode = 2'b01; imm9 = 9'h1FF;
    #1;
    tests++;
    if (ext9_o !== exp_ff) begin fails++; $display("FAIL ext9_1ff_comb got=%h exp=%h", ext9_o, exp_ff); end
    step();
    tests++;
    if (imm_q !== exp_ff) begin fails++; $display("FAIL ext9_1ff_reg got=%h exp=%h", imm_q, exp_ff); end
    imm9 = 9'h0AB;
    step();
    tests++;
    if (ext9_o !== 16'h00AB) begin fails++; $display("FAIL ext9_0ab_comb got=%h exp=00ab", ext9_o); end
    tests++;
    if (imm_q !== 16'h00AB) begin fails++; $display("FAIL ext9_0ab_reg got=%h exp=00ab", imm_q); end
  endtask

  task automatic test_doubling();
    logic [15:0] exp9;
`ifdef IMM_EXT_SEXT9_EN
    exp9 = 16'hFFFE;
`else
    exp9 = 16'h03FE;
`endif
    en = 1'b1; in_valid = 1'b1;
    mode = 2'b10; imm6 = 6'b100000;
    step();
    tests++;
    if (imm_q !== 16'hFFC0) begin fails++; $display("FAIL dbl6_neg got=%h exp=ffc0", imm_q); end
    mode = 2'b11; imm9 = 9'h1FF;
    step();
    tests++;
    if (imm_q !== exp9) begin fails++; $display("FAIL dbl9_1ff got=%h exp=%h", imm_q, exp9); end
    mode = 2'b10; imm6 = 6'b000011;
    step();
    tests++;
    if (imm_q !== 16'h0006) begin fails++; $display("FAIL dbl6_3 got=%h exp=0006", imm_q); end
  endtask

  task automatic test_stall();
    en = 1'b1; in_valid = 1'b1; mode = 2'b00; imm6 = 6'd5;
    step();
    tests++;
    if (imm_q !== 16'h0005) begin fails++; $display("FAIL stall_load got=%h exp=0005", imm_q); end
    en = 1'b0; imm6 = 6'd7; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (imm_q !== 16'h0005 || valid_q !== 1'b1) begin
        fails++; $display("FAIL stall_hold[%0d] got=%h/%b exp=0005/1", i, imm_q, valid_q);
      end
    end
    tests++;
    if (sext6_o !== 16'h0007) begin fails++; $display("FAIL stall_comb got=%h exp=0007", sext6_o); end
    // Enabled with in_valid low: operand still loads, valid drops.
    en = 1'b1;
    step();
    tests++;
    if (imm_q !== 16'h0007 || valid_q !== 1'b0) begin
      fails++; $display("FAIL invalid_load got=%h/%b exp=0007/0", imm_q, valid_q);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; in_valid = 1'b1; mode = 2'b00; imm6 = 6'h3F;
    step();
    tests++;
    if (imm_q !== 16'hFFFF || valid_q !== 1'b1) begin
      fails++; $display("FAIL areset_pre got=%h/%b exp=ffff/1", imm_q, valid_q);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (imm_q !== 16'h0000 || valid_q !== 1'b0) begin
      fails++; $display("FAIL areset_clear got=%h/%b exp=0000/0", imm_q, valid_q);
    end
    imm6 = 6'b100001;
    #1;
    tests++;
    if (sext6_o !== 16'hFFE1) begin fails++; $display("FAIL areset_comb got=%h exp=ffe1", sext6_o); end
    step();
    tests++;
    if (imm_q !== 16'h0000) begin fails++; $display("FAIL areset_edge got=%h exp=0000", imm_q); end
    #2;
    reset = 1'b0;
    mode = 2'b10; imm6 = 6'd3;
    step();
    tests++;
    if (imm_q !== 16'h0006 || valid_q !== 1'b1) begin
      fails++; $display("FAIL areset_release got=%h/%b exp=0006/1", imm_q, valid_q);
    end
  endtask

  task automatic test_random_sweep();
    logic [15:0] exp;
    logic        expv;
    en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imm6 = i[5:0];
      mode = i[7:6];
      imm9 = 9'($urandom_range(0, 511));
      in_valid = 1'($urandom_range(0, 1));
      exp = ref_sel(imm6, imm9, mode);
      expv = in_valid;
      #1;
      tests++;
      if (sext6_o !== to16(ref_v6(imm6)) || ext9_o !== to16(ref_v9(imm9))) begin
        fails++; $display("FAIL sweep6_comb imm6=%h imm9=%h got=%h/%h exp=%h/%h",
                          imm6, imm9, sext6_o, ext9_o, to16(ref_v6(imm6)), to16(ref_v9(imm9)));
      end
      step();
      tests++;
      if (imm_q !== exp || valid_q !== expv) begin
        fails++; $display("FAIL sweep6_reg imm6=%h mode=%b got=%h/%b exp=%h/%b",
                          imm6, mode, imm_q, valid_q, exp, expv);
      end
    end
    for (int i = 0; i < 512; i++) begin
      imm9 = i[8:0];
      imm6 = 6'($urandom_range(0, 63));
      mode = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      exp = ref_sel(imm6, imm9, mode);
      expv = in_valid;
      #1;
      tests++;
      if (ext9_o !== to16(ref_v9(imm9))) begin
        fails++; $display("FAIL sweep9_comb imm9=%h got=%h exp=%h", imm9, ext9_o, to16(ref_v9(imm9)));
      end
      step();
      tests++;
      if (imm_q !== exp || valid_q !== expv) begin
        fails++; $display("FAIL sweep9_reg imm9=%h imm6=%h mode=%b got=%h/%b exp=%h/%b",
                          imm9, imm6, mode, imm_q, valid_q, exp, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sign_boundaries();
    test_ext9();
    test_doubling();
    test_stall();
    test_async_reset();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_imm_extend_unit

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Immediate-field extension block for the 16-bit 6-stage RISC pipeline, used in the decode/register-read stage.
- Sign-extends the 6-bit immediate and zero-extends the 9-bit immediate (formed from the rb field and imm6) to 16 bits.
- Optionally doubles either result to form a branch/jump byte offset.
- Provides combinational results plus a registered, mode-selected operand for the next pipeline stage.

Parameters:
- DATA_W, 16, output data width.
- IMM6_W, 6, short immediate width (sign-extended).
- IMM9_W, 9, long immediate width (zero-extended unless the optional feature is enabled).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  stage enable; 0 = stall, hold registered outputs.
- imm6  input  6  short immediate.
- imm9  input  9  long immediate, {rb[2:0], imm6}.
- mode  input  2  00 EXT6, 01 EXT9, 10 EXT6x2, 11 EXT9x2.
- in_valid  input  1  instruction in decode carries an immediate.
- sext6_o  output  16  combinational sign extension of imm6.
- ext9_o  output  16  combinational extension of imm9.
- imm_q  output  16  registered, mode-selected operand.
- valid_q  output  1  registered in_valid.

Behaviour:
- sext6_o = {10{imm6[5]}, imm6}. This output is purely combinational, with zero latency.
- ext9_o = {7'b0, imm9}. With IMM_EXT_SEXT9_EN defined it is {7{imm9[8]}, imm9} instead. Also combinational.
- Selected value sel:
  - EXT6 gives sext6_o.
  - EXT9 gives ext9_o.
  - EXT6x2 gives sext6_o << 1.
  - EXT9x2 gives ext9_o << 1.
- Shift arithmetic is modulo 2^16: the MSB shifted out is discarded and bit 0 becomes 0. There is no overflow flag.
- Register stage, 1-cycle latency:
  - On a rising edge of clk with en=1: imm_q <= sel and valid_q <= in_valid.
  - With en=0: imm_q and valid_q hold their values.
  - When in_valid=0 and en=1: valid_q <= 0, and imm_q still loads sel.
- Reset:
  - reset=1 asynchronously forces imm_q=16'h0000 and valid_q=0, regardless of clk or en.
  - Reset asserted mid-operation clears both immediately.
  - The first capture after release occurs on the first rising edge with reset=0 and en=1.
- Combinational outputs are not affected by reset; they track imm6/imm9 at all times.
- Boundaries:
  - imm6=6'b100000 gives 0xFFE0 (most negative).
  - imm6=6'b011111 gives 0x001F.
  - imm9=9'h1FF gives 0x01FF (zero-extend) or 0xFFFF (sign-extend feature).
- No X propagation is permitted: every mode value maps to a defined result.

Optional Feature:
- Macro IMM_EXT_SEXT9_EN.
- When defined: the 9-bit path sign-extends imm9 (bit 8 replicated). This affects ext9_o, EXT9 and EXT9x2.
- When undefined (default): the 9-bit path zero-extends.
- The 6-bit path is identical in both builds.

Decomposition:
- Shared package imm_ext_pkg:
  - Mode enum: EXT6=2'b00, EXT9=2'b01, EXT6X2=2'b10, EXT9X2=2'b11.
  - Width constants: DATA_W, IMM6_W, IMM9_W.
- One natural sub-module, imm_ext_core: purely combinational extenders and mode mux.
- The top level imm_extend_unit adds the enable/reset pipeline register.

Test Plan:
- Sign boundaries, mode=00:
  - imm6=6'b111111 gives sext6_o=0xFFFF.
  - imm6=6'b011111 gives 0x001F.
  - imm6=6'b100000 gives 0xFFE0.
  - imm_q shows each value one clock later.
- 9-bit extension, mode=01, imm9=9'h1FF:
  - Default build gives ext9_o=imm_q=0x01FF.
  - IMM_EXT_SEXT9_EN build gives 0xFFFF.
  - imm9=9'h0AB gives 0x00AB in both builds.
- Doubling:
  - mode=10, imm6=6'b100000 gives imm_q=0xFFC0.
  - mode=11, imm9=9'h1FF gives imm_q=0x03FE (default build).
  - mode=10, imm6=6'b000011 gives 0x0006.
- Stall: load imm6=5 with mode=00 and en=1, giving imm_q=0x0005. Then en=0 with imm6=7 for 3 clocks gives imm_q=0x0005 and valid_q unchanged.
- Async reset:
  - With imm_q=0xFFFF and valid_q=1, pulse reset between clock edges: imm_q=0x0000 and valid_q=0 immediately, while sext6_o still follows imm6.
  - After release, the first en=1 edge loads the new value.
- Random sweep: all 64 imm6 × 4 modes plus 512 imm9 values are compared against a reference model, with imm_q checked at 1-cycle latency.
